exec_ctrl: RTL and testbench
============================

# exec_ctrl

Run-control sequencer and data-memory arbiter for the single-cycle processor. It holds the processor in reset while an external host loads or inspects data memory, then releases it, counts executed cycles, and detects halt or a watchdog timeout. It also multiplexes the single data-memory write/address port between the processor's load/store path and the host port, giving the CPU priority while running.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- CNT_W, 32, cycle-counter width
- MAX_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- start  in  1  host pulse: begin execution
- clear  in  1  host pulse: abort the run or acknowledge completion
- halt_in  in  1  registered halt flag from the processor
- cpu_req, cpu_we  in  1 each  processor data-memory access and write strobe
- cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W
- ext_req, ext_we  in  1 each  host access and write strobe
- ext_addr  in  ADDR_W; ext_wdata  in  DATA_W
- ext_gnt  out  1  host access accepted this cycle
- mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  to data memory
- cpu_en  out  1  processor clock-enable
- proc_rst  out  1  processor reset, active-high
- state  out  2  current state
- cycle_count  out  CNT_W  RUN cycles elapsed
- done  out  1  high in HALTED
- timeout  out  1  high in TIMEOUT

## Operation
- States: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- IDLE: proc_rst=1, cpu_en=0. Host owns memory. start → RUN, with cycle_count cleared to 0. clear is ignored.
- RUN: proc_rst=0, cpu_en=1. cycle_count increments every cycle.
  - halt_in=1 → HALTED.
  - Otherwise, if MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1 → TIMEOUT.
  - Otherwise clear → IDLE (abort). start is ignored.
- Priority in RUN: halt_in > watchdog > clear.
- HALTED and TIMEOUT: proc_rst=0, cpu_en=0, processor state is frozen for inspection, cycle_count holds. Host owns memory. clear → IDLE. start is ignored.
- Arbitration:
  - In IDLE, HALTED and TIMEOUT: ext_gnt=ext_req.
  - In RUN: ext_gnt = ext_req & ~cpu_req. The host must hold its request until granted.
  - Memory port carries the cpu_* signals when the CPU owns it, ext_* when ext_gnt=1, and otherwise mem_we=0 with mem_addr/mem_wdata=0.
  - mem_we is gated with the owner's request.
- cycle_count wraps modulo 2^CNT_W when the watchdog is disabled.

## Timing
- Reset values: state=IDLE, proc_rst=1, cpu_en=0, cycle_count=0, done=0, timeout=0, ext_gnt=0.
- state, proc_rst, cpu_en, cycle_count, done and timeout are registered; all update on the same edge as the state change.
- ext_gnt and the memory-port signals are combinational from the current state and the request inputs; no latency.
- start sampled at edge N in IDLE: cpu_en=1 and proc_rst=0 after edge N. First RUN edge N+1 sets cycle_count=1.
- halt_in=1 sampled at edge M in RUN: cpu_en=0 and done=1 after M. cycle_count includes edge M.
- Reset asserted mid-run: immediate asynchronous return to reset values; a write in flight is dropped.

## Structure
- Shared package exec_pkg holds:
  - the state encoding constants (IDLE, RUN, HALTED, TIMEOUT);
  - the default widths.
- One natural sub-module, mem_port_arb:
  - combinational owner select and port muxing;
  - inputs are state, the cpu_* signals and the ext_* signals.
- The FSM, counter and watchdog stay in exec_ctrl.

## Test plan
- Reset then host write ext_addr=0x10, ext_wdata=0xDEADBEEF in IDLE → ext_gnt=1, mem_we=1, mem_addr=0x10, proc_rst=1.
- start, then halt_in asserted on the 5th RUN edge → state=HALTED, done=1, cpu_en=0, cycle_count=5 and holding. clear → IDLE, done=0.
- RUN with cpu_req=1 and ext_req=1 at the same time → ext_gnt=0 and mem_addr=cpu_addr. Next cycle cpu_req=0 → ext_gnt=1.
- MAX_CYCLES=8, halt_in never set → TIMEOUT after edge 8, cycle_count=8, timeout=1. halt_in and the watchdog in the same cycle (edge 8) → HALTED.
- clear on the 3rd RUN edge → IDLE, proc_rst=1. A following start restarts with cycle_count=0.
- Async reset pulsed mid-RUN between edges → all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the run-control sequencer: state encoding and default widths.
package exec_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCntW  = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2,
    StTimeout = 2'd3
  } state_e;

endpackage

// File: rtl/exec_ctrl_if.sv
// Data-memory bus bundle: CPU and host request ports plus the shared memory port.
interface exec_ctrl_if
  import exec_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Requesters (processor and host) drive the master side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arb.sv
// Combinational owner select for the single data-memory port; the CPU wins only while running.
module mem_port_arb
  import exec_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  state_e            i_state,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata
);

  logic w_cpu_own;

  assign w_cpu_own = (i_state == StRun) && i_cpu_req;

  always_comb begin
    o_ext_gnt   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_cpu_own) begin
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (i_ext_req) begin
      o_ext_gnt   = 1'b1;
      o_mem_we    = i_ext_we;
      o_mem_addr  = i_ext_addr;
      o_mem_wdata = i_ext_wdata;
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Run-control sequencer: holds the CPU in reset for host memory access, runs it,
// counts cycles and stops on halt or watchdog expiry.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_halt_in,
  exec_ctrl_if.slave       bus,
  output logic             o_cpu_en,
  output logic             o_proc_rst,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic             o_done,
  output logic             o_timeout
);

  localparam bit             WdEn   = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(MAX_CYCLES - 1);

  state_e           r_state;
  logic             r_cpu_en;
  logic             r_proc_rst;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_done;
  logic             r_timeout;

  logic              w_ext_gnt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cpu_en      <= 1'b0;
      r_proc_rst    <= 1'b1;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state       <= StRun;
            r_cycle_count <= '0;
            r_proc_rst    <= 1'b0;
            r_cpu_en      <= 1'b1;
          end
        end
        StRun: begin
          // The edge that leaves RUN still counts as an executed cycle.
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (i_halt_in) begin
            r_state  <= StHalted;
            r_cpu_en <= 1'b0;
            r_done   <= 1'b1;
          end else if (WdEn && (r_cycle_count == WdLast)) begin
            r_state   <= StTimeout;
            r_cpu_en  <= 1'b0;
            r_timeout <= 1'b1;
          end else if (i_clear) begin
            r_state    <= StIdle;
            r_cpu_en   <= 1'b0;
            r_proc_rst <= 1'b1;
          end
        end
        StHalted, StTimeout: begin
          if (i_clear) begin
            r_state    <= StIdle;
            r_proc_rst <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  mem_port_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_port_arb (
    .i_state     (r_state),
    .i_cpu_req   (bus.cpu_req),
    .i_cpu_we    (bus.cpu_we),
    .i_cpu_addr  (bus.cpu_addr),
    .i_cpu_wdata (bus.cpu_wdata),
    .i_ext_req   (bus.ext_req),
    .i_ext_we    (bus.ext_we),
    .i_ext_addr  (bus.ext_addr),
    .i_ext_wdata (bus.ext_wdata),
    .o_ext_gnt   (w_ext_gnt),
    .o_mem_we    (w_mem_we),
    .o_mem_addr  (w_mem_addr),
    .o_mem_wdata (w_mem_wdata)
  );

  // Reset blanks the memory port so an access in flight is dropped at once.
  assign bus.ext_gnt   = w_ext_gnt & i_rst_n;
  assign bus.mem_we    = w_mem_we & i_rst_n;
  assign bus.mem_addr  = i_rst_n ? w_mem_addr : '0;
  assign bus.mem_wdata = i_rst_n ? w_mem_wdata : '0;

  assign o_state       = r_state;
  assign o_cpu_en      = r_cpu_en;
  assign o_proc_rst    = r_proc_rst;
  assign o_cycle_count = r_cycle_count;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: directed stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        halt_in;
  logic        cpu_en;
  logic        proc_rst;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        done;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        name;
    logic [103:0] v;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         cur;
  logic [103:0] got;

  exec_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  exec_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .CNT_W      (32),
    .MAX_CYCLES (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_clear       (clear),
    .i_halt_in     (halt_in),
    .bus           (bus),
    .o_cpu_en      (cpu_en),
    .o_proc_rst    (proc_rst),
    .o_state       (state),
    .o_cycle_count (cycle_count),
    .o_done        (done),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  assign got = {state, proc_rst, cpu_en, done, timeout, bus.ext_gnt, bus.mem_we,
                cycle_count, bus.mem_addr, bus.mem_wdata};

  function automatic string fmt(input logic [103:0] v);
    return $sformatf("st=%0d prst=%0b cen=%0b done=%0b to=%0b gnt=%0b we=%0b cnt=%0d addr=%h wd=%h",
                     v[103:102], v[101], v[100], v[99], v[98], v[97], v[96],
                     v[95:64], v[63:32], v[31:0]);
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      n_checks++;
      if (got !== cur.v) begin
        n_errors++;
        $display("FAIL %s: got %s, want %s", cur.name, fmt(got), fmt(cur.v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expected snapshot; the monitor compares it at the next falling edge.
  task automatic chk(input string nm, input logic [1:0] st, input logic prst, input logic cen,
                     input logic [31:0] cnt, input logic dn, input logic to, input logic gnt,
                     input logic we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.name = nm;
    e.v    = {st, prst, cen, dn, to, gnt, we, cnt, addr, wd};
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    bus.ext_req   = req;
    bus.ext_we    = we;
    bus.ext_addr  = a;
    bus.ext_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    halt_in = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_ext(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);

    // Host write during reset is dropped.
    step();
    chk("reset", 2'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    rst_n = 1'b1;
    step();
    chk("host_wr", 2'd0, 1, 0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);

    set_ext(1'b0, 1'b0, 32'h0, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start", 2'd1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    repeat (4) step();
    chk("run4", 2'd1, 0, 1, 4, 0, 0, 0, 0, 32'h0, 32'h0);

    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    chk("halted", 2'd2, 0, 0, 5, 1, 0, 0, 0, 32'h0, 32'h0);

    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("halt_hold", 2'd2, 0, 0, 5, 1, 0, 0, 0, 32'h0, 32'h0);

    set_ext(1'b1, 1'b0, 32'h20, 32'h1234);
    step();
    chk("halted_rd", 2'd2, 0, 0, 5, 1, 0, 1, 0, 32'h20, 32'h1234);

    set_ext(1'b0, 1'b0, 32'h0, 32'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_halt", 2'd0, 1, 0, 5, 0, 0, 0, 0, 32'h0, 32'h0);

    // Both requesters active in RUN: CPU wins, host waits.
    start = 1'b1;
    set_cpu(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
    set_ext(1'b1, 1'b1, 32'h80, 32'h5A5A5A5A);
    step();
    start = 1'b0;
    chk("arb_cpu", 2'd1, 0, 1, 0, 0, 0, 0, 1, 32'h40, 32'hA5A5A5A5);

    step();
    bus.cpu_req = 1'b0;
    chk("arb_ext", 2'd1, 0, 1, 1, 0, 0, 1, 1, 32'h80, 32'h5A5A5A5A);

    step();
    bus.ext_req = 1'b0;
    chk("arb_none", 2'd1, 0, 1, 2, 0, 0, 0, 0, 32'h0, 32'h0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_abort", 2'd0, 1, 0, 3, 0, 0, 0, 0, 32'h0, 32'h0);

    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_ext(1'b0, 1'b0, 32'h0, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart", 2'd1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    repeat (7) step();
    chk("pre_wd", 2'd1, 0, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0);

    step();
    chk("timeout", 2'd3, 0, 0, 8, 0, 1, 0, 0, 32'h0, 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_hold", 2'd3, 0, 0, 8, 0, 1, 0, 0, 32'h0, 32'h0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_to", 2'd0, 1, 0, 8, 0, 0, 0, 0, 32'h0, 32'h0);

    // halt_in coincides with watchdog expiry on edge 8: halt wins.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    chk("halt_wd", 2'd2, 0, 0, 8, 1, 0, 0, 0, 32'h0, 32'h0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear2", 2'd0, 1, 0, 8, 0, 0, 0, 0, 32'h0, 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    set_cpu(1'b1, 1'b1, 32'hC0, 32'h11223344);
    chk("run_wr", 2'd1, 0, 1, 2, 0, 0, 0, 1, 32'hC0, 32'h11223344);

    // Reset lands between edges; the check precedes the next rising edge.
    step();
    rst_n = 1'b0;
    chk("async_rst", 2'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst", 2'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    repeat (3) step();
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
